fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  PC generator and fetch buffer directly upstream of instruction_mem in the single-cycle core.
//  Drives the memory word address from its PC register, captures the combinational instruction word
//  the same cycle, and queues {pc, instr} pairs in a small FIFO. Decode drains the FIFO through
//  a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC.
// PARAMETERS
//  PC_WIDTH    64   width of PC and redirect target
//  ADDR_WIDTH  10   instruction memory word-address bits; memory uses pc[ADDR_WIDTH+1:2]
//  RESET_PC    0    PC value loaded on reset
//  BUF_DEPTH   2    fetch FIFO entries; power of two, >=2
// PORTS
//  clk             in   1         rising-edge clock
//  rst_n           in   1         asynchronous active-low reset
//  fetch_en        in   1         level; 1 = fetching permitted
//  imem_pc         out  PC_WIDTH  address to instruction memory (= PC register)
//  imem_instr      in   32        instruction word at imem_pc, valid same cycle
//  redirect_valid  in   1         1-cycle pulse: flush and load redirect_pc
//  redirect_pc     in   PC_WIDTH  new fetch target; bits [1:0] forced to 0 on load
//  out_valid       out  1         FIFO head valid
//  out_ready       in   1         decode accepts head this cycle
//  out_pc          out  PC_WIDTH  PC of head instruction
//  out_instr       out  32        head instruction; 32'h0000_0013 (NOP) when !out_valid
// BEHAVIOUR
//  Reset: PC=RESET_PC, FIFO empty, state S_IDLE, out_valid=0, out_pc=0, out_instr=NOP.
//  FSM (3 states):
//   S_IDLE:  no fetch; -> S_RUN when fetch_en=1.
//   S_RUN:   fetch per rules below; -> S_IDLE if fetch_en=0; -> S_FLUSH on redirect_valid.
//   S_FLUSH: one bubble cycle, no push; -> S_RUN (S_IDLE if fetch_en=0). Redirect here reloads PC, stays S_FLUSH.
//  Redirect (any state): in the same clock edge, FIFO cleared, PC <= {redirect_pc[PC_WIDTH-1:2],2'b00}.
//   No push that cycle; a pop handshake that cycle is discarded (decode must also squash).
//   In S_IDLE redirect only reloads PC; state unchanged.
//  Push: in S_RUN, no redirect, and (!full || pop). Entry = {PC, imem_instr}; PC <= PC + 4.
//  Pop: out_valid && out_ready. Simultaneous push+pop when full is legal; count unchanged.
//  Latency: instruction at PC visible on out_* the cycle after its push (1-cycle fetch latency);
//   steady-state throughput 1 instr/cycle with out_ready held 1.
//  Full: PC holds, imem_pc stable, no push. Empty: out_valid=0.
//  PC arithmetic modulo 2^PC_WIDTH; PC at all-ones-minus-3 wraps to 0. Memory aliasing above
//   ADDR_WIDTH+2 bits is the memory's concern, not checked here.
//  Reset asserted mid-operation: all state cleared immediately (asynchronous), outputs to reset values.
//  fetch_en falling: in-flight FIFO contents still drain to decode.
//  out_* driven directly from FIFO head registers; no combinational path imem_instr -> out_*.
// STRUCTURE
//  fetch_pkg: typedef fetch_entry_t {logic [PC_WIDTH-1:0] pc; logic [31:0] instr;},
//   enum fetch_state_t {S_IDLE,S_RUN,S_FLUSH}, localparam INSTR_NOP=32'h0000_0013, INSTR_BYTES=4.
//  Sub-module fetch_fifo (BUF_DEPTH, entry type): push/pop/flush, full/empty, wrap-around
//   read/write pointers with extra MSB for full detection. fetch_unit holds PC, FSM, glue.
// TESTING
//  1 Reset release, fetch_en=1, out_ready=1, mem[i]=i -> out_pc 0,4,8,... one/cycle from cycle 2; out_instr matches.
//  2 out_ready=0 for 5 cycles -> FIFO fills to 2, imem_pc holds at 0x8; release -> 0x0,0x4,0x8 in order, no loss/dup.
//  3 redirect_valid with redirect_pc=0x103 while FIFO full -> next out_valid=0, then out_pc=0x100 after bubble; old entries gone.
//  4 RESET_PC=2^64-8: fetch -> out_pc FFFF_FFFF_FFFF_FFF8, ...FFFC, then 0x0 (wrap).
//  5 fetch_en=0 mid-stream -> no new pushes, queued entries drain, out_valid drops; re-enable resumes at next PC.
//  6 rst_n low asynchronously mid-stream with FIFO full -> out_valid=0, out_instr=NOP, imem_pc=RESET_PC before next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Entry layout, FSM state encoding, NOP word and instruction size.
package fetch_pkg;

    localparam int FETCH_PC_WIDTH = 64;
    localparam int INSTR_BYTES    = 4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_PC_WIDTH-1:0] pc;
        logic [31:0]               instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO of {pc, instr} entries.
// Ports: push/push_data, pop, flush (clears), head, full, empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   flush,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);

    // Pointers carry one extra MSB so full and empty differ.
    logic [PW:0] wptr_q, wptr_d;
    logic [PW:0] rptr_q, rptr_d;
    entry_t      mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + ONE;
            if (pop)  rptr_d = rptr_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; empty gates everything downstream.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q[PW-1:0]] <= push_data;
    end

    assign head  = mem_q[rptr_q[PW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

endmodule

// File: rtl/fetch_unit.sv
// PC generator and fetch buffer feeding decode over valid/ready.
// Ports: fetch_en, imem_pc/imem_instr, redirect_*, out_valid/ready/pc/instr.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  ADDR_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  BUF_DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    output logic [PC_WIDTH-1:0] imem_pc,
    input  logic [31:0]         imem_instr,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [31:0]         out_instr
);

    if (ADDR_WIDTH + 2 > PC_WIDTH) begin : g_bad_addr
        $error("ADDR_WIDTH too large for PC_WIDTH");
    end
    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("BUF_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instr;
    } entry_t;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_BYTES);

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                push, pop, full, empty;
    entry_t              push_data, head;
    logic                unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc[1:0];

    assign pop  = !empty && out_ready;
    assign push = (state_q == S_RUN) && !redirect_valid && (!full || pop);
    assign push_data = '{pc: pc_q, instr: imem_instr};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!redirect_valid && fetch_en) state_d = S_RUN;
            S_RUN: begin
                if (redirect_valid) state_d = S_FLUSH;
                else if (!fetch_en) state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (!redirect_valid) state_d = fetch_en ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
        else if (push)      pc_d = pc_q + STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A pop coinciding with a redirect is swallowed by the flush.
    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign imem_pc   = pc_q;
    assign out_valid = !empty;
    assign out_pc    = empty ? '0 : head.pc;
    assign out_instr = empty ? INSTR_NOP : head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, async reset,
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    // Memory image: word i holds value i (10-bit word address).
    function automatic logic [31:0] mem_word(logic [63:0] a);
        return {22'b0, a[11:2]};
    endfunction

    assign imem_instr = mem_word(imem_pc);

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    bit          m_on;      // fetching has started
    bit          m_bubble;  // post-redirect dead cycle pending

    function automatic void model_reset();
        m_q.delete();
        m_pc     = '0;
        m_on     = 0;
        m_bubble = 0;
    endfunction

    function automatic void model_step();
        bit pop;
        pop = (m_q.size() > 0) && out_ready;
        if (redirect_valid) begin
            m_q.delete();
            m_pc = {redirect_pc[63:2], 2'b00};
            if (m_on) m_bubble = 1;
        end else if (!m_on) begin
            if (pop) void'(m_q.pop_front());
            m_on = fetch_en;
        end else if (m_bubble) begin
            if (pop) void'(m_q.pop_front());
            m_bubble = 0;
            m_on = fetch_en;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_q.size() < 2) begin
                m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc = m_pc + 64'd4;
            end
            m_on = fetch_en;
        end
    endfunction

    task automatic check(string name, logic ev, logic [63:0] epc,
                         logic [31:0] ei, logic [63:0] eim);
        n_checks++;
        if (out_valid !== ev || out_pc !== epc ||
            out_instr !== ei || imem_pc !== eim) begin
            n_fail++;
            $display("FAIL %s: got v=%0b pc=%h instr=%h imem=%h, want v=%0b pc=%h instr=%h imem=%h",
                     name, out_valid, out_pc, out_instr, imem_pc,
                     ev, epc, ei, eim);
        end
    endtask

    task automatic check_model(string name);
        if (m_q.size() > 0)
            check(name, 1'b1, m_q[0].pc, m_q[0].instr, m_pc);
        else
            check(name, 1'b0, 64'd0, NOP, m_pc);
    endtask

    // One clock: update model with the inputs now applied, then compare.
    task automatic step(string name);
        model_step();
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        en;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        ev;
        logic [63:0] epc;
        logic [31:0] ei;
        logic [63:0] eim;
    } vec_t;

    vec_t tbl[25];

    initial begin
        localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFF8;
        // stall from start, fill, release
        tbl[0]  = '{1, 0, 0, 0, 0, 64'h0,   NOP,       64'h0};
        tbl[1]  = '{1, 0, 0, 0, 1, 64'h0,   32'h0,     64'h4};
        tbl[2]  = '{1, 0, 0, 0, 1, 64'h0,   32'h0,     64'h8};
        tbl[3]  = '{1, 0, 0, 0, 1, 64'h0,   32'h0,     64'h8};
        tbl[4]  = '{1, 0, 0, 0, 1, 64'h0,   32'h0,     64'h8};
        tbl[5]  = '{1, 0, 0, 0, 1, 64'h0,   32'h0,     64'h8};
        tbl[6]  = '{1, 1, 0, 0, 1, 64'h4,   32'h1,     64'hC};
        tbl[7]  = '{1, 1, 0, 0, 1, 64'h8,   32'h2,     64'h10};
        tbl[8]  = '{1, 1, 0, 0, 1, 64'hC,   32'h3,     64'h14};
        tbl[9]  = '{1, 0, 0, 0, 1, 64'hC,   32'h3,     64'h14};
        // redirect while full
        tbl[10] = '{1, 1, 1, 64'h103, 0, 64'h0, NOP,   64'h100};
        tbl[11] = '{1, 1, 0, 0, 0, 64'h0,   NOP,       64'h100};
        tbl[12] = '{1, 1, 0, 0, 1, 64'h100, 32'h40,    64'h104};
        tbl[13] = '{1, 1, 0, 0, 1, 64'h104, 32'h41,    64'h108};
        // wrap at top of address space
        tbl[14] = '{1, 1, 1, TOP, 0, 64'h0, NOP,       TOP};
        tbl[15] = '{1, 1, 0, 0, 0, 64'h0,   NOP,       TOP};
        tbl[16] = '{1, 1, 0, 0, 1, TOP,     32'h3FE,   TOP + 64'd4};
        tbl[17] = '{1, 1, 0, 0, 1, TOP + 64'd4, 32'h3FF, 64'h0};
        tbl[18] = '{1, 1, 0, 0, 1, 64'h0,   32'h0,     64'h4};
        // fetch_en drop, drain, resume
        tbl[19] = '{0, 0, 0, 0, 1, 64'h0,   32'h0,     64'h8};
        tbl[20] = '{0, 0, 0, 0, 1, 64'h0,   32'h0,     64'h8};
        tbl[21] = '{0, 1, 0, 0, 1, 64'h4,   32'h1,     64'h8};
        tbl[22] = '{0, 1, 0, 0, 0, 64'h0,   NOP,       64'h8};
        tbl[23] = '{1, 1, 0, 0, 0, 64'h0,   NOP,       64'h8};
        tbl[24] = '{1, 1, 0, 0, 1, 64'h8,   32'h2,     64'hC};
    end

    initial begin
        #12;
        check("reset", 1'b0, 64'h0, NOP, 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            fetch_en       = tbl[i].en;
            out_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            step($sformatf("model_row%0d", i));
            check($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc,
                  tbl[i].ei, tbl[i].eim);
        end
        redirect_valid = 1'b0;

        // throughput: one instruction per cycle with ready held high
        for (int i = 0; i < 4; i++) begin
            fetch_en  = 1'b1;
            out_ready = 1'b1;
            step("stream");
            check("stream_pc", 1'b1, 64'hC + 64'(4 * i),
                  mem_word(64'hC + 64'(4 * i)), 64'h10 + 64'(4 * i));
        end

        // async reset with FIFO full, checked before the next edge
        out_ready = 1'b0;
        repeat (3) step("prefill");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 64'h0, NOP, 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 |
                              64'($urandom_range(0, 31));
            else
                redirect_pc = {$urandom, $urandom};
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
